zjh_scan_disp: RTL and testbench
================================

// Module: zjh_scan_disp
// PURPOSE
//  Parametrised multiplexed 7-segment display scanner; successor to the 2-bit counter + 74HC138 driver.
//  Prescaler tick advances a DIGITS-wide scan counter. The counter drives active-low one-hot digit selects and a hex->7seg decode of the selected nibble.
//  Adds clock-enable, per-digit blanking, frame-synchronous double-buffered load (valid/ready) and a frame_done pulse.
//  Sits between the counter/data datapath and the board's digit-select and segment pins.
// PARAMETERS
//  DIGITS    4     number of multiplexed digits (1..8)
//  SEL_W     $clog2(DIGITS) (min 1)  scan index width (localparam)
//  PRESCALE  1000  Clock cycles per digit slot (>=1)
//  PS_W      $clog2(PRESCALE) (min 1)  prescaler width (localparam)
// PORTS
//  Clock       in   1          single system clock, rising edge
//  Aclr        in   1          asynchronous, active-low reset
//  En          in   1          1 = prescaler and scan run; 0 = freeze, outputs held
//  ld_valid    in   1          new display word offered
//  ld_data     in   4*DIGITS   nibble i = digit i (digit 0 in [3:0])
//  ld_ready    out  1          1 = shadow buffer free, ld_data accepted on valid&ready
//  blank_mask  in   DIGITS     bit i = 1 -> digit i dark during its slot
//  Y           out  DIGITS     digit selects, active-low one-hot (0 = digit on)
//  seg         out  7          {g,f,e,d,c,b,a}, active-high
//  scan_idx    out  SEL_W      currently displayed digit
//  frame_done  out  1          1-cycle pulse on scan wrap (DIGITS-1 -> 0)
// BEHAVIOUR
//  Reset (Aclr=0, async):
//   - prescaler=0, scan_idx=0, shadow=0, pending=0, disp_buf=0.
//   - Y=all 1s (all digits off), seg=0, frame_done=0, ld_ready=1.
//  Prescaler:
//   - counts 0..PRESCALE-1 while En=1; tick = (count==PRESCALE-1) & En; wraps to 0.
//   - En=0 holds count.
//  Scan:
//   - on tick, scan_idx <= (scan_idx==DIGITS-1) ? 0 : scan_idx+1.
//   - Y and seg are registered from the next index, so they change on the same edge as scan_idx. No combinational path from inputs to outputs.
//   - Y = ~(1<<idx_next), except blank_mask[idx_next]=1 -> Y=all 1s, seg=0.
//   - blank_mask is sampled at the tick edge.
//  First tick after reset selects digit 1 (digit 0's slot is the dark reset slot).
//  Segment decode:
//   - 0..F standard hex; A,b,C,d,E,F shapes.
//   - 0=7'h3F, 1=7'h06, 8=7'h7F, F=7'h71.
//  Load handshake:
//   - ld_ready = ~pending.
//   - valid&ready at an edge: shadow<=ld_data, pending<=1.
//   - ld_valid may drop without acceptance; no requirement to hold.
//  Frame-synchronous transfer:
//   - at a wrap tick with pending=1: disp_buf<=shadow, pending<=0.
//   - ld_ready rises on the following cycle.
//   - The decode for digit 0 on that same edge uses the NEW disp_buf value (bypass), so a frame never mixes old and new words.
//  frame_done: 1 for the cycle following each wrap tick.
//  Simultaneous events:
//   - accept and wrap on the same edge cannot coincide (ready implies pending=0); the accepted word waits for the next wrap.
//   - En=0 blocks wrap, so pending stays set and loads stall.
//  DIGITS=1: every tick is a wrap; Y toggles only by blanking.
//  PRESCALE=1: tick every enabled cycle.
//  Aclr mid-frame: pending word discarded; all state returns to reset values.
// STRUCTURE
//  - Shared package zjh_disp_pkg: SEG_HEX[16] 7-bit constant table, SEG_OFF=7'h00, Y_OFF helper function.
//  - One sub-module, zjh_hex7seg: combinational 4->7 decoder from SEG_HEX.
//  - Top contains the prescaler, scan counter, shadow/disp buffers, handshake and output registers.
// TESTING
//  (DIGITS=4, PRESCALE=4 unless noted)
//  1. Reset: Aclr=0 mid-run -> Y=4'hF, seg=0, ld_ready=1, scan_idx=0 immediately, asynchronous to Clock.
//  2. Load 16'h1234, En=1:
//     - first wrap -> slots show digit0 seg=7'h66 ('4'), digit1 7'h4F, digit2 7'h5B, digit3 7'h06.
//     - Y sequence: E,D,B,7.
//     - tick period = 4 cycles.
//  3. Second ld_valid while pending -> ld_ready=0, data not taken.
//     - frame_done pulses once per 16 cycles.
//     - ld_ready=1 the cycle after the wrap.
//  4. blank_mask=4'b0100 -> during digit2 slot Y=4'hF, seg=0; other slots unaffected.
//  5. En=0 for 10 cycles mid-slot -> Y, seg, scan_idx and prescaler frozen.
//     - pending load not transferred.
//     - resumes with the exact remaining slot count.
//  6. DIGITS=1, PRESCALE=1 -> frame_done every enabled cycle.
//     - load 4'hF appears next cycle as seg=7'h71, Y=1'b0.

Source files
------------

// File: rtl/zjh_disp_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: hex glyph table,
// dark-segment value and the all-digits-off select pattern.
package zjh_disp_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Segment order {g,f,e,d,c,b,a}; A,b,C,d,E,F glyph shapes for 10..15
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [7:0] Y_OFF(input int digits);
    return 8'hFF >> (8 - digits);
  endfunction

endpackage

// File: rtl/zjh_hex7seg.sv
// Combinational hex nibble to 7-segment decoder.
module zjh_hex7seg
  import zjh_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/zjh_scan_disp.sv
// Multiplexed 7-segment scanner: prescaled digit scan, per-digit blanking and
// a frame-synchronous double-buffered display word with valid/ready load.
module zjh_scan_disp
  import zjh_disp_pkg::*;
#(
  parameter  int DIGITS   = 4,
  parameter  int PRESCALE = 1000,
  localparam int SEL_W    = (DIGITS   > 1) ? $clog2(DIGITS)   : 1,
  localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic                  Clock,
  input  logic                  Aclr,
  input  logic                  En,
  input  logic                  ld_valid,
  input  logic [4*DIGITS-1:0]   ld_data,
  output logic                  ld_ready,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [DIGITS-1:0]     Y,
  output logic [6:0]            seg,
  output logic [SEL_W-1:0]      scan_idx,
  output logic                  frame_done
);

  localparam logic [DIGITS-1:0] Y_ALL = DIGITS'(Y_OFF(DIGITS));

  logic [PS_W-1:0]     ps_cnt;
  logic                tick;
  logic                wrap;
  logic                pending;
  logic [SEL_W-1:0]    idx_next;
  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] disp_buf;
  logic [4*DIGITS-1:0] src_buf;
  logic [3:0]          nibble;
  logic [6:0]          seg_dec;
  logic [DIGITS-1:0]   y_next;
  logic                blank_sel;

  assign tick     = En && (ps_cnt == PS_W'(PRESCALE - 1));
  assign wrap     = tick && (scan_idx == SEL_W'(DIGITS - 1));
  assign idx_next = wrap ? '0 : scan_idx + SEL_W'(1);
  assign ld_ready = ~pending;

  // Digit 0 of a new frame decodes from the word being transferred on this edge
  assign src_buf  = (wrap && pending) ? shadow : disp_buf;

  always_comb begin
    nibble    = '0;
    y_next    = Y_ALL;
    blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_next == SEL_W'(i)) begin
        nibble    = src_buf[4*i +: 4];
        y_next    = ~(DIGITS'(1) << i);
        blank_sel = blank_mask[i];
      end
    end
  end

  zjh_hex7seg u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      ps_cnt <= '0;
    end else if (En) begin
      ps_cnt <= (ps_cnt == PS_W'(PRESCALE - 1)) ? '0 : ps_cnt + PS_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      scan_idx   <= '0;
      Y          <= Y_ALL;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) begin
        scan_idx <= idx_next;
        Y        <= blank_sel ? Y_ALL   : y_next;
        seg      <= blank_sel ? SEG_OFF : seg_dec;
      end
    end
  end

  // An accept can never coincide with a transfer: accept needs pending=0
  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      shadow   <= '0;
      disp_buf <= '0;
      pending  <= 1'b0;
    end else if (ld_valid && !pending) begin
      shadow   <= ld_data;
      pending  <= 1'b1;
    end else if (wrap && pending) begin
      disp_buf <= shadow;
      pending  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zjh_scan_disp.sv
// Bench for zjh_scan_disp: directed sequences on a 4-digit/PRESCALE=4 and a
// 1-digit/PRESCALE=1 instance, then randomized traffic against a frame-level model.
module tb_zjh_scan_disp;

  localparam int D4 = 4;
  localparam int P4 = 4;

  logic        clk = 1'b0;
  logic        aclr;
  logic        en, vld;
  logic [15:0] dat;
  logic [3:0]  blank;
  logic        rdy;
  logic [3:0]  y;
  logic [6:0]  seg;
  logic [1:0]  idx;
  logic        fd;

  logic        en1, vld1;
  logic [3:0]  dat1;
  logic        blank1;
  logic        rdy1;
  logic        y1;
  logic [6:0]  seg1;
  logic        idx1;
  logic        fd1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  zjh_scan_disp #(.DIGITS(D4), .PRESCALE(P4)) dut4 (
    .Clock(clk), .Aclr(aclr), .En(en), .ld_valid(vld), .ld_data(dat),
    .ld_ready(rdy), .blank_mask(blank), .Y(y), .seg(seg), .scan_idx(idx),
    .frame_done(fd)
  );

  zjh_scan_disp #(.DIGITS(1), .PRESCALE(1)) dut1 (
    .Clock(clk), .Aclr(aclr), .En(en1), .ld_valid(vld1), .ld_data(dat1),
    .ld_ready(rdy1), .blank_mask(blank1), .Y(y1), .seg(seg1), .scan_idx(idx1),
    .frame_done(fd1)
  );

  int hex_tbl [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                       'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  // Model of the 4-digit instance: slot position, displayed word, waiting word
  int m_ps, m_idx, m_pend, m_shadow, m_disp, m_y, m_seg, m_fd;

  task automatic model_reset();
    m_ps = 0; m_idx = 0; m_pend = 0; m_shadow = 0; m_disp = 0;
    m_y = 'hF; m_seg = 0; m_fd = 0;
  endtask

  task automatic model_step();
    bit tk, wr;
    int nidx, word;
    tk = en && (m_ps == P4 - 1);
    wr = tk && (m_idx == D4 - 1);
    if (en) m_ps = (m_ps + 1) % P4;
    if (tk) begin
      nidx = (m_idx + 1) % D4;
      word = (wr && m_pend != 0) ? m_shadow : m_disp;
      if (blank[nidx]) begin
        m_y = 'hF; m_seg = 0;
      end else begin
        m_y   = 'hF ^ (1 << nidx);
        m_seg = hex_tbl[(word >> (4 * nidx)) & 'hF];
      end
      m_idx = nidx;
    end
    m_fd = wr;
    if (m_pend == 0 && vld) begin
      m_shadow = int'(dat); m_pend = 1;
    end else if (wr && m_pend != 0) begin
      m_disp = m_shadow; m_pend = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 aclr = 1'b0;
    #1;
    check("rst_y",    32'(y),   32'hF);
    check("rst_seg",  32'(seg), 32'h0);
    check("rst_rdy",  32'(rdy), 32'h1);
    check("rst_idx",  32'(idx), 32'h0);
    check("rst_fd",   32'(fd),  32'h0);
    check("rst_y1",   32'(y1),  32'h1);
    @(negedge clk);
    aclr = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int         gap;
    logic [3:0] bl;
    logic [3:0] ey;
    logic [6:0] es;
    logic       efd;
  } scan_vec_t;

  typedef struct {
    logic [3:0] d;
    logic [6:0] s;
  } dec_vec_t;

  scan_vec_t svec [8];
  dec_vec_t  dvec [16];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    svec[0] = '{3, 4'b0000, 4'hD, 7'h4F, 1'b0};
    svec[1] = '{4, 4'b0000, 4'hB, 7'h5B, 1'b0};
    svec[2] = '{4, 4'b0000, 4'h7, 7'h06, 1'b0};
    svec[3] = '{4, 4'b0100, 4'hE, 7'h66, 1'b1};
    svec[4] = '{4, 4'b0100, 4'hD, 7'h4F, 1'b0};
    svec[5] = '{4, 4'b0100, 4'hF, 7'h00, 1'b0};
    svec[6] = '{4, 4'b0100, 4'h7, 7'h06, 1'b0};
    svec[7] = '{4, 4'b0000, 4'hE, 7'h66, 1'b1};
    dvec[0]  = '{4'h0, 7'h3F}; dvec[1]  = '{4'h1, 7'h06};
    dvec[2]  = '{4'h2, 7'h5B}; dvec[3]  = '{4'h3, 7'h4F};
    dvec[4]  = '{4'h4, 7'h66}; dvec[5]  = '{4'h5, 7'h6D};
    dvec[6]  = '{4'h6, 7'h7D}; dvec[7]  = '{4'h7, 7'h07};
    dvec[8]  = '{4'h8, 7'h7F}; dvec[9]  = '{4'h9, 7'h6F};
    dvec[10] = '{4'hA, 7'h77}; dvec[11] = '{4'hB, 7'h7C};
    dvec[12] = '{4'hC, 7'h39}; dvec[13] = '{4'hD, 7'h5E};
    dvec[14] = '{4'hE, 7'h79}; dvec[15] = '{4'hF, 7'h71};

    aclr = 1'b0;
    en = 0; vld = 0; dat = '0; blank = '0;
    en1 = 0; vld1 = 0; dat1 = '0; blank1 = 0;
    model_reset();
    do_reset();

    // Load 1234, then a second offer while pending
    en = 1; vld = 1; dat = 16'h1234;
    cyc(1);
    check("acc_rdy", 32'(rdy), 32'h0);
    dat = 16'hABCD;
    cyc(1);
    check("busy_rdy", 32'(rdy), 32'h0);
    vld = 0;
    cyc(1);
    check("slot0_idx", 32'(idx), 32'h0);
    cyc(1);
    check("tick4_idx", 32'(idx), 32'h1);
    check("tick4_y",   32'(y),   32'hD);
    check("tick4_seg", 32'(seg), 32'h3F);
    cyc(11);
    check("prewrap_rdy", 32'(rdy), 32'h0);
    check("prewrap_fd",  32'(fd),  32'h0);
    cyc(1);
    check("wrap_y",   32'(y),   32'hE);
    check("wrap_seg", 32'(seg), 32'h66);
    check("wrap_fd",  32'(fd),  32'h1);
    check("wrap_rdy", 32'(rdy), 32'h1);
    check("wrap_idx", 32'(idx), 32'h0);
    cyc(1);
    check("fd_pulse", 32'(fd), 32'h0);

    foreach (svec[k]) begin
      blank = svec[k].bl;
      cyc(svec[k].gap);
      check($sformatf("scan%0d_y", k),   32'(y),   32'(svec[k].ey));
      check($sformatf("scan%0d_seg", k), 32'(seg), 32'(svec[k].es));
      check($sformatf("scan%0d_fd", k),  32'(fd),  32'(svec[k].efd));
    end

    // Freeze mid-slot with a word pending
    vld = 1; dat = 16'h5678;
    cyc(1);
    vld = 0;
    check("frz_acc_rdy", 32'(rdy), 32'h0);
    cyc(1);
    en = 0;
    cyc(10);
    check("frz_y",   32'(y),   32'hE);
    check("frz_seg", 32'(seg), 32'h66);
    check("frz_idx", 32'(idx), 32'h0);
    check("frz_rdy", 32'(rdy), 32'h0);
    check("frz_fd",  32'(fd),  32'h0);
    en = 1;
    cyc(1);
    check("resume_idx0", 32'(idx), 32'h0);
    cyc(1);
    check("resume_idx1", 32'(idx), 32'h1);
    check("resume_y",    32'(y),   32'hD);
    check("resume_seg",  32'(seg), 32'h4F);
    cyc(12);
    check("new_y",   32'(y),   32'hE);
    check("new_seg", 32'(seg), 32'h7F);
    check("new_fd",  32'(fd),  32'h1);
    check("new_rdy", 32'(rdy), 32'h1);

    // Single-digit instance, tick every enabled cycle
    en = 0;
    do_reset();
    en1 = 1;
    foreach (dvec[k]) begin
      vld1 = 1; dat1 = dvec[k].d;
      cyc(1);
      vld1 = 0;
      check($sformatf("d1_%0h_rdy0", k), 32'(rdy1), 32'h0);
      check($sformatf("d1_%0h_fd", k),   32'(fd1),  32'h1);
      cyc(1);
      check($sformatf("d1_%0h_seg", k),  32'(seg1), 32'(dvec[k].s));
      check($sformatf("d1_%0h_y", k),    32'(y1),   32'h0);
      check($sformatf("d1_%0h_rdy1", k), 32'(rdy1), 32'h1);
    end
    blank1 = 1;
    cyc(1);
    check("d1_blank_y",   32'(y1),   32'h1);
    check("d1_blank_seg", 32'(seg1), 32'h0);
    blank1 = 0;
    cyc(1);
    check("d1_unblank_seg", 32'(seg1), 32'h71);
    check("d1_unblank_y",   32'(y1),   32'h0);
    en1 = 0;
    cyc(1);
    check("d1_dis_fd", 32'(fd1), 32'h0);

    // Randomized traffic against the model, with one mid-run reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 7) != 0);
      vld   = ($urandom_range(0, 3) == 0);
      dat   = 16'($urandom);
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      cyc(1);
      check("rnd_y",   32'(y),   32'(m_y));
      check("rnd_seg", 32'(seg), 32'(m_seg));
      check("rnd_idx", 32'(idx), 32'(m_idx));
      check("rnd_rdy", 32'(rdy), 32'(m_pend == 0));
      check("rnd_fd",  32'(fd),  32'(m_fd));
      if (i == 1500) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
